dest_tag_pipe: RTL and testbench
================================

DEST_TAG_PIPE -- requirements
Module: dest_tag_pipe

Interface
REQ-001 SHALL have parameter: rfWidth, 3, register-address width.
REQ-002 SHALL have parameter: nRegs, 2**rfWidth, register count (scoreboard depth).
REQ-003 SHALL have port: clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port: rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: idValid  input  1  ID holds a real instruction.
REQ-006 SHALL have port: idDest  input  rfWidth  destination register of ID instruction.
REQ-007 SHALL have port: idWriteEn  input  1  ID instruction writes the register file.
REQ-008 SHALL have port: idIsLoad  input  1  ID instruction is a load.
REQ-009 SHALL have port: stall  input  1  load-use stall from the forwarding unit.
REQ-010 SHALL have port: flush  input  1  taken branch/jump; kill the ID instruction.
REQ-011 SHALL have ports: rfWriteAddrEx, rfWriteAddrMem, rfWriteAddrWb  output  rfWidth each  stage destination tags.
REQ-012 SHALL have ports: exWriteEn, memWriteEn, wbWriteEn  output  1 each  stage write-valid flags.
REQ-013 SHALL have ports: isLoadInEx, isLoadInMem  output  1 each  load present in stage.
REQ-014 SHALL have port: pendingMask  output  nRegs  bit r set while any in-flight write targets r.

Function
REQ-015 SHALL advance EX->MEM->WB every cycle unconditionally; only the ID->EX transfer is conditioned.
REQ-016 SHALL load EX with a bubble (addr 0, writeEn 0, load 0) when idValid=0, stall=1, or flush=1; flush and stall together SHALL give a single bubble.
REQ-017 SHALL otherwise load EX with idDest, idIsLoad, and writeEn = idWriteEn AND (idDest != 0).
REQ-018 SHALL give fixed latency: ID accepted at edge n appears on Ex outputs after edge n, Mem after n+1, Wb after n+2, retires at edge n+3.
REQ-019 SHALL propagate isLoad into MEM with the tag; isLoadInEx/isLoadInMem SHALL be registered outputs.
REQ-020 SHALL keep a 2-bit saturating-free counter per register: +1 when a writing instruction enters EX, -1 when a writing instruction leaves WB.
REQ-021 SHALL leave a counter unchanged on simultaneous increment and decrement of the same register.
REQ-022 SHALL never exceed count 3 (three stages); counter 0 SHALL stay 0 (writes to r0 never counted).
REQ-023 SHALL drive pendingMask[r] = (count[r] != 0), registered-state derived, no combinational path from ID inputs.
REQ-024 SHALL not depend on stage outputs combinationally from stall/flush; all outputs change only on clk or rst.

Reset
REQ-025 SHALL, on rst low, immediately clear all tags, writeEn and isLoad flags in every stage, all counters and pendingMask to 0.
REQ-026 SHALL discard in-flight instructions on reset mid-operation; first valid accept resumes at the first edge after rst rises.

Structure
REQ-027 SHALL take rfWidth, stage count (3) and the forwarding select codes (IDSEL=0, EXSEL=1, MEMSEL=2, WBSEL=3) from a shared pipeline package also used by the forwarding unit.
REQ-028 SHALL instantiate one sub-module, tag_stage_reg (addr, writeEn, isLoad register with bubble input), three times.

Verification
REQ-029 SHALL test single issue: idDest=5, idWriteEn=1 at edge 0 -> rfWriteAddrEx=5/exWriteEn=1 after edge 0, Mem after 1, Wb after 2; pendingMask=0x20 for edges 0..2, 0x00 after edge 3.
REQ-030 SHALL test load-use: load to r3 then stall=1 one cycle -> EX bubble (exWriteEn=0) while r3 tag sits in MEM with isLoadInMem=1.
REQ-031 SHALL test back-to-back writes to r2 for 3 cycles -> count reaches 3, pendingMask[2]=1 until third retires; fourth issue coinciding with first retire keeps count 3.
REQ-032 SHALL test write to r0 with idWriteEn=1 -> exWriteEn=0, pendingMask stays 0x00.
REQ-033 SHALL test flush=1 with idValid=1, idDest=6 -> EX bubble, pendingMask[6] never set.
REQ-034 SHALL test rst low while r1,r4,r7 in flight -> all outputs 0 immediately, pendingMask=0x00 without waiting for retire.

Source files
------------

// File: rtl/dest_tag_pipe_pkg.sv
// Shared pipeline constants: register-file width, stage count, forwarding
// select codes, and the per-register in-flight counter update rule.
package dest_tag_pipe_pkg;

    localparam int RF_WIDTH = 3;
    localparam int N_STAGES = 3;
    localparam int CNT_W    = 2;

    typedef enum logic [1:0] {
        IDSEL  = 2'd0,
        EXSEL  = 2'd1,
        MEMSEL = 2'd2,
        WBSEL  = 2'd3
    } fwd_sel_t;

    // Simultaneous enter and retire of the same register cancel out.
    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                  input logic inc,
                                                  input logic dec);
        logic [CNT_W-1:0] res;
        case ({inc, dec})
            2'b10:   res = cnt + 2'd1;
            2'b01:   res = cnt - 2'd1;
            default: res = cnt;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dest_tag_pipe_tag_stage.sv
// One pipeline stage of destination tag, write-valid and load flag, with a
// bubble input that loads an empty slot instead of the upstream contents.
module tag_stage_reg #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         bubble,
    input  logic [W-1:0] next_addr,
    input  logic         next_we,
    input  logic         next_ld,
    output logic [W-1:0] addr,
    output logic         we,
    output logic         ld
);

    // Stage register: cleared by reset, emptied by bubble, else loads upstream.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr <= {W{1'b0}};
            we   <= 1'b0;
            ld   <= 1'b0;
        end else if (bubble) begin
            addr <= {W{1'b0}};
            we   <= 1'b0;
            ld   <= 1'b0;
        end else begin
            addr <= next_addr;
            we   <= next_we;
            ld   <= next_ld;
        end
    end

endmodule

// File: rtl/dest_tag_pipe.sv
// Destination-tag pipeline EX->MEM->WB with a per-register in-flight
// scoreboard whose non-zero counters form pendingMask.
module dest_tag_pipe
    import dest_tag_pipe_pkg::*;
#(
    parameter int rfWidth = RF_WIDTH,
    parameter int nRegs   = 2**rfWidth
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               idValid,
    input  logic [rfWidth-1:0] idDest,
    input  logic               idWriteEn,
    input  logic               idIsLoad,
    input  logic               stall,
    input  logic               flush,
    output logic [rfWidth-1:0] rfWriteAddrEx,
    output logic [rfWidth-1:0] rfWriteAddrMem,
    output logic [rfWidth-1:0] rfWriteAddrWb,
    output logic               exWriteEn,
    output logic               memWriteEn,
    output logic               wbWriteEn,
    output logic               isLoadInEx,
    output logic               isLoadInMem,
    output logic [nRegs-1:0]   pendingMask
);

    logic             ex_bubble_s;
    logic             ex_we_s;
    logic             wb_load_unused_s;
    logic [nRegs-1:0] inc_s;
    logic [nRegs-1:0] dec_s;
    logic [CNT_W-1:0] cnt_r [nRegs];

    assign ex_bubble_s = !idValid || stall || flush;
    assign ex_we_s     = idWriteEn && (idDest != {rfWidth{1'b0}});

    tag_stage_reg #(.W(rfWidth)) u_ex (
        .clk       (clk),
        .rst       (rst),
        .bubble    (ex_bubble_s),
        .next_addr (idDest),
        .next_we   (ex_we_s),
        .next_ld   (idIsLoad),
        .addr      (rfWriteAddrEx),
        .we        (exWriteEn),
        .ld        (isLoadInEx)
    );

    tag_stage_reg #(.W(rfWidth)) u_mem (
        .clk       (clk),
        .rst       (rst),
        .bubble    (1'b0),
        .next_addr (rfWriteAddrEx),
        .next_we   (exWriteEn),
        .next_ld   (isLoadInEx),
        .addr      (rfWriteAddrMem),
        .we        (memWriteEn),
        .ld        (isLoadInMem)
    );

    tag_stage_reg #(.W(rfWidth)) u_wb (
        .clk       (clk),
        .rst       (rst),
        .bubble    (1'b0),
        .next_addr (rfWriteAddrMem),
        .next_we   (memWriteEn),
        .next_ld   (isLoadInMem),
        .addr      (rfWriteAddrWb),
        .we        (wbWriteEn),
        .ld        (wb_load_unused_s)
    );

    // One-hot enter (into EX) and retire (out of WB) strobes per register.
    always_comb begin
        inc_s = {nRegs{1'b0}};
        dec_s = {nRegs{1'b0}};
        if (!ex_bubble_s && ex_we_s) begin
            inc_s[idDest] = 1'b1;
        end else begin
            inc_s = {nRegs{1'b0}};
        end
        if (wbWriteEn) begin
            dec_s[rfWriteAddrWb] = 1'b1;
        end else begin
            dec_s = {nRegs{1'b0}};
        end
    end

    // In-flight write counters; r0 is never counted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < nRegs; r++) begin
                cnt_r[r] <= 2'd0;
            end
        end else begin
            cnt_r[0] <= 2'd0;
            for (int r = 1; r < nRegs; r++) begin
                cnt_r[r] <= cnt_next(cnt_r[r], inc_s[r], dec_s[r]);
            end
        end
    end

    // Pending bits come only from counter state, never from ID inputs.
    always_comb begin
        pendingMask = {nRegs{1'b0}};
        for (int r = 0; r < nRegs; r++) begin
            pendingMask[r] = (cnt_r[r] != 2'd0);
        end
    end

endmodule

// File: tb/tb_dest_tag_pipe.sv
// Directed and random checks of dest_tag_pipe against a queue-of-instructions
// model: each edge pushes the accepted instruction (or a bubble), oldest drops.
module tb_dest_tag_pipe;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       idValid = 1'b0;
    logic [2:0] idDest = 3'd0;
    logic       idWriteEn = 1'b0;
    logic       idIsLoad = 1'b0;
    logic       stall = 1'b0;
    logic       flush = 1'b0;
    logic [2:0] rfWriteAddrEx;
    logic [2:0] rfWriteAddrMem;
    logic [2:0] rfWriteAddrWb;
    logic       exWriteEn;
    logic       memWriteEn;
    logic       wbWriteEn;
    logic       isLoadInEx;
    logic       isLoadInMem;
    logic [7:0] pendingMask;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [2:0] addr;
        logic       we;
        logic       ld;
    } instr_t;

    instr_t pipe[$];

    dest_tag_pipe dut (
        .clk            (clk),
        .rst            (rst),
        .idValid        (idValid),
        .idDest         (idDest),
        .idWriteEn      (idWriteEn),
        .idIsLoad       (idIsLoad),
        .stall          (stall),
        .flush          (flush),
        .rfWriteAddrEx  (rfWriteAddrEx),
        .rfWriteAddrMem (rfWriteAddrMem),
        .rfWriteAddrWb  (rfWriteAddrWb),
        .exWriteEn      (exWriteEn),
        .memWriteEn     (memWriteEn),
        .wbWriteEn      (wbWriteEn),
        .isLoadInEx     (isLoadInEx),
        .isLoadInMem    (isLoadInMem),
        .pendingMask    (pendingMask)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        instr_t b;
        b.addr = 3'd0;
        b.we   = 1'b0;
        b.ld   = 1'b0;
        pipe.delete();
        for (int i = 0; i < 3; i++) pipe.push_back(b);
    endtask

    task automatic model_edge();
        instr_t n;
        n.addr = 3'd0;
        n.we   = 1'b0;
        n.ld   = 1'b0;
        if (idValid && !stall && !flush) begin
            n.addr = idDest;
            n.we   = idWriteEn && (idDest != 3'd0);
            n.ld   = idIsLoad;
        end
        pipe.push_front(n);
        pipe.delete(3);
    endtask

    function automatic logic [7:0] exp_mask();
        logic [7:0] m = 8'h00;
        foreach (pipe[i]) if (pipe[i].we) m[pipe[i].addr] = 1'b1;
        return m;
    endfunction

    task automatic check_all();
        chk("ex_addr",  rfWriteAddrEx,  pipe[0].addr);
        chk("mem_addr", rfWriteAddrMem, pipe[1].addr);
        chk("wb_addr",  rfWriteAddrWb,  pipe[2].addr);
        chk("ex_we",    exWriteEn,      pipe[0].we);
        chk("mem_we",   memWriteEn,     pipe[1].we);
        chk("wb_we",    wbWriteEn,      pipe[2].we);
        chk("ex_ld",    isLoadInEx,     pipe[0].ld);
        chk("mem_ld",   isLoadInMem,    pipe[1].ld);
        chk("pending",  pendingMask,    exp_mask());
    endtask

    // Drive at the falling edge, advance model at the rising edge, sample 1 later.
    task automatic step(input bit v, input logic [2:0] d, input bit w, input bit l,
                        input bit s, input bit f);
        idValid   = v;
        idDest    = d;
        idWriteEn = w;
        idIsLoad  = l;
        stall     = s;
        flush     = f;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic async_reset();
        #2;
        rst = 1'b0;
        model_clear();
        #1;
        check_all();
        chk("rst_pending", pendingMask, 32'h00);
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        model_clear();
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b1;

        // Single issue to r5 and its retirement.
        step(1'b1, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("single_mask0", pendingMask, 32'h20);
        idle(2);
        chk("single_mask2", pendingMask, 32'h20);
        chk("single_wb", rfWriteAddrWb, 32'd5);
        idle(1);
        chk("single_mask3", pendingMask, 32'h00);

        // Load to r3 followed by a one-cycle stall.
        step(1'b1, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("lu_ex_we", exWriteEn, 32'd0);
        chk("lu_mem_ld", isLoadInMem, 32'd1);
        chk("lu_mem_addr", rfWriteAddrMem, 32'd3);
        idle(3);

        // Back-to-back r2 writes, fourth coinciding with the first retire.
        for (int i = 0; i < 4; i++) step(1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("b2b_mask", pendingMask, 32'h04);
        idle(2);
        chk("b2b_tail", pendingMask, 32'h04);
        idle(1);
        chk("b2b_done", pendingMask, 32'h00);

        // Write to r0 never counts.
        step(1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("r0_we", exWriteEn, 32'd0);
        chk("r0_mask", pendingMask, 32'h00);
        idle(3);

        // Flush, then flush+stall together.
        step(1'b1, 3'd6, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("flush_we", exWriteEn, 32'd0);
        step(1'b1, 3'd6, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("flush_stall_ld", isLoadInEx, 32'd0);
        idle(3);
        chk("flush_mask", pendingMask, 32'h00);

        // Reset mid-flight with r1, r4, r7 in the pipe.
        step(1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_mask", pendingMask, 32'h92);
        async_reset();
        step(1'b1, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("post_rst_mask", pendingMask, 32'h20);
        idle(3);

        // Random traffic with occasional asynchronous resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                async_reset();
            end else begin
                step($urandom_range(0, 9) < 8, 3'($urandom_range(0, 7)),
                     $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                     $urandom_range(0, 6) == 0, $urandom_range(0, 9) == 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
